portal_mmio_bridge: RTL and testbench

// - Upstream stage of the portal top: turns single-beat CPU reads/writes on a simple valid/ready MMIO bus into
//   the top's select/enable handshakes (select_request/en_request, select_indication/en_indication).
// - Writes to a request data register enqueue 32-bit words; reads of an indication data register dequeue words.
// - Status and interrupt-channel reads are non-destructive.
// - One outstanding transaction at a time.

---
 rtl/portal_bridge_pkg.sv | 19 +
 rtl/portal_mmio_bridge_if.sv | 34 +++
 rtl/portal_mmio_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_portal_mmio_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/portal_bridge_pkg.sv
// portal_bridge_pkg: shared types and constants for the portal MMIO bridge.
// The mask offset is only decoded when PORTAL_IRQ_MASK_EN is defined.
package portal_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        WR_RESP,
        RD_RESP
    } state_t;

    localparam logic [3:0]  OFF_DATA     = 4'd0;
    localparam logic [3:0]  OFF_STATUS   = 4'd1;
    localparam logic [3:0]  OFF_INTR     = 4'd2;
    localparam logic [11:0] OFF_IRQ_MASK = 12'h200;
    localparam logic [31:0] ERR_DATA     = 32'hDEAD_0000;

endpackage

// File: rtl/portal_mmio_bridge_if.sv
// portal_mmio_bridge_if: single-beat valid/ready MMIO bus between CPU and bridge.
// master = CPU side, slave = bridge side.
interface portal_mmio_bridge_if #(
    parameter int ADDR_W = 12
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_resp_valid;
    logic              wr_resp_ready;
    logic              wr_resp_err;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_resp_valid;
    logic              rd_resp_ready;
    logic [31:0]       rd_resp_data;
    logic              rd_resp_err;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_resp_ready,
        output rd_valid, rd_addr, rd_resp_ready,
        input  wr_ready, wr_resp_valid, wr_resp_err,
        input  rd_ready, rd_resp_valid, rd_resp_data, rd_resp_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_resp_ready,
        input  rd_valid, rd_addr, rd_resp_ready,
        output wr_ready, wr_resp_valid, wr_resp_err,
        output rd_ready, rd_resp_valid, rd_resp_data, rd_resp_err
    );
endinterface

// File: rtl/portal_mmio_bridge.sv
// portal_mmio_bridge: MMIO reads/writes to portal select/enable handshakes.
// Define PORTAL_IRQ_MASK_EN to add the irq mask register at 0x200.
module portal_mmio_bridge
    import portal_bridge_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int NUM_IND = 2,
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 12
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    portal_mmio_bridge_if.slave  bus,
    output logic [1:0]           select_request,
    output logic [31:0]          request_enq_v,
    output logic                 en_request,
    input  logic                 rdy_request_enq,
    input  logic                 request_not_full,
    output logic [1:0]           select_indication,
    output logic                 en_indication,
    input  logic                 rdy_indication,
    input  logic [31:0]          indication_data,
    input  logic                 indication_not_empty,
    input  logic [31:0]          req_intr_channel,
    input  logic [31:0]          ind_intr_channel,
    output logic                 irq
);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic [3:0]  off_q, off_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  sel_req_q, sel_req_d;
    logic [1:0]  sel_ind_q, sel_ind_d;
`ifdef PORTAL_IRQ_MASK_EN
    logic [1:0]  mask_q, mask_d;
`endif

    logic              acc_rd;
    logic [ADDR_W-1:0] acc_addr;
    logic              a_dir;
    logic [1:0]        a_ch;
    logic [3:0]        a_off;
    logic              ch_ok, off_ok, a_ok, a_mask;
    logic              timed_out;
    logic [31:0]       stat_data;
    logic              en_req_c, en_ind_c;
    logic              unused_addr;

    // A simultaneous read wins, so the request address comes from the read port.
    assign acc_rd   = bus.rd_valid;
    assign acc_addr = acc_rd ? bus.rd_addr : bus.wr_addr;
    assign a_dir    = acc_addr[8];
    assign a_ch     = acc_addr[7:6];
    assign a_off    = acc_addr[5:2];
    assign unused_addr = ^acc_addr[1:0];

    assign ch_ok  = a_dir ? ({30'd0, a_ch} < 32'(NUM_IND))
                          : ({30'd0, a_ch} < 32'(NUM_REQ));
    assign off_ok = (a_off == OFF_STATUS) || (a_off == OFF_INTR) ||
                    ((a_off == OFF_DATA) && (a_dir == acc_rd));
    assign a_ok   = (acc_addr[ADDR_W-1:9] == '0) && ch_ok && off_ok;
`ifdef PORTAL_IRQ_MASK_EN
    assign a_mask = ({acc_addr[ADDR_W-1:2], 2'b00} == ADDR_W'(OFF_IRQ_MASK));
`else
    assign a_mask = 1'b0;
`endif

    assign timed_out = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        stat_data = '0;
        if (off_q == OFF_STATUS) begin
            stat_data[0] = dir_q ? indication_not_empty : request_not_full;
        end else begin
            stat_data = dir_q ? ind_intr_channel : req_intr_channel;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        off_d     = off_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        sel_req_d = sel_req_q;
        sel_ind_d = sel_ind_q;
`ifdef PORTAL_IRQ_MASK_EN
        mask_d    = mask_q;
`endif
        en_req_c  = 1'b0;
        en_ind_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rd_valid || bus.wr_valid) begin
                    dir_d = a_dir;
                    off_d = a_off;
                    cnt_d = '0;
                    if (!acc_rd) data_d = bus.wr_data;
                    unique case (1'b1)
                        a_mask: begin
                            err_d   = 1'b0;
                            rdata_d = '0;
`ifdef PORTAL_IRQ_MASK_EN
                            rdata_d = {30'd0, mask_q};
                            if (!acc_rd) mask_d = bus.wr_data[1:0];
`endif
                            state_d = acc_rd ? RD_RESP : WR_RESP;
                        end
                        a_ok: begin
                            err_d = 1'b0;
                            if (a_dir) sel_ind_d = a_ch;
                            else       sel_req_d = a_ch;
                            state_d = acc_rd ? RD_WAIT : WR_WAIT;
                        end
                        default: begin
                            err_d   = 1'b1;
                            rdata_d = ERR_DATA;
                            state_d = acc_rd ? RD_RESP : WR_RESP;
                        end
                    endcase
                end
            end
            WR_WAIT: begin
                if (off_q != OFF_DATA) begin
                    state_d = WR_RESP;
                end else if (rdy_request_enq) begin
                    en_req_c = 1'b1;
                    state_d  = WR_RESP;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    state_d = WR_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_WAIT: begin
                if (off_q != OFF_DATA) begin
                    rdata_d = stat_data;
                    state_d = RD_RESP;
                end else if (rdy_indication) begin
                    en_ind_c = 1'b1;
                    rdata_d  = indication_data;
                    state_d  = RD_RESP;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_RESP: if (bus.wr_resp_ready) state_d = IDLE;
            RD_RESP: if (bus.rd_resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            off_q     <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            sel_req_q <= '0;
            sel_ind_q <= '0;
`ifdef PORTAL_IRQ_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            off_q     <= off_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            sel_req_q <= sel_req_d;
            sel_ind_q <= sel_ind_d;
`ifdef PORTAL_IRQ_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    // wr_ready drops while a read is offered so a yielded write is not lost.
    assign bus.rd_ready      = RST_N && (state_q == IDLE);
    assign bus.wr_ready      = RST_N && (state_q == IDLE) && !bus.rd_valid;
    assign bus.rd_resp_valid = RST_N && (state_q == RD_RESP);
    assign bus.wr_resp_valid = RST_N && (state_q == WR_RESP);
    assign bus.rd_resp_data  = rdata_q;
    assign bus.rd_resp_err   = err_q;
    assign bus.wr_resp_err   = err_q;

    assign select_request    = sel_req_q;
    assign select_indication = sel_ind_q;
    assign request_enq_v     = data_q;
    assign en_request        = RST_N && en_req_c;
    assign en_indication     = RST_N && en_ind_c;

`ifdef PORTAL_IRQ_MASK_EN
    assign irq = RST_N && (((req_intr_channel != '0) && mask_q[0]) ||
                           ((ind_intr_channel != '0) && mask_q[1]));
`else
    assign irq = RST_N && ((req_intr_channel != '0) || (ind_intr_channel != '0));
`endif

endmodule

// File: tb/tb_portal_mmio_bridge.sv
// tb_portal_mmio_bridge: vector table plus corner sequences for portal_mmio_bridge.
// Responses are checked against a scoreboard queue filled when stimulus is issued.
module tb_portal_mmio_bridge;

    localparam int NEVER = 100000;
    localparam logic [31:0] ERR = 32'hDEAD_0000;

    typedef struct {
        bit          rd;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] ind_data;
        bit          nf;
        bit          ne;
        logic [31:0] rintr;
        logic [31:0] iintr;
        bit          exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_enr;
        int          exp_eni;
        logic [1:0]  exp_selr;
        logic [1:0]  exp_seli;
    } vec_t;

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  select_request;
    logic [31:0] request_enq_v;
    logic        en_request;
    logic        rdy_request_enq;
    logic        request_not_full;
    logic [1:0]  select_indication;
    logic        en_indication;
    logic        rdy_indication;
    logic [31:0] indication_data;
    logic        indication_not_empty;
    logic [31:0] req_intr_channel;
    logic [31:0] ind_intr_channel;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int enr_cnt = 0;
    int eni_cnt = 0;
    sb_t  sb[$];
    vec_t vecs[$];

    portal_mmio_bridge_if #(.ADDR_W(12)) bus ();

    portal_mmio_bridge dut (
        .CLK                  (clk),
        .RST_N                (rst_n),
        .bus                  (bus),
        .select_request       (select_request),
        .request_enq_v        (request_enq_v),
        .en_request           (en_request),
        .rdy_request_enq      (rdy_request_enq),
        .request_not_full     (request_not_full),
        .select_indication    (select_indication),
        .en_indication        (en_indication),
        .rdy_indication       (rdy_indication),
        .indication_data      (indication_data),
        .indication_not_empty (indication_not_empty),
        .req_intr_channel     (req_intr_channel),
        .ind_intr_channel     (ind_intr_channel),
        .irq                  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_resp(input bit rd, input bit err, input logic [31:0] data);
        sb_t e;
        if (sb.size() == 0) begin
            chk("resp_unexpected", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("resp_kind", {31'd0, rd}, {31'd0, e.rd});
        chk("resp_err", {31'd0, err}, {31'd0, e.err});
        if (rd) chk("resp_data", data, e.data);
    endtask

    always @(negedge clk) begin
        if (en_request) enr_cnt++;
        if (en_indication) eni_cnt++;
        if (en_request || en_indication)
            chk("strobe_excl", {31'd0, en_request & en_indication}, 32'd0);
        if (bus.rd_resp_valid && bus.rd_resp_ready)
            check_resp(1'b1, bus.rd_resp_err, bus.rd_resp_data);
        if (bus.wr_resp_valid && bus.wr_resp_ready)
            check_resp(1'b0, bus.wr_resp_err, 32'd0);
    end

    task automatic run_vec(input vec_t v);
        int n;
        int lat;
        bit acc;
        int enr0;
        int eni0;
        enr0 = enr_cnt;
        eni0 = eni_cnt;
        indication_data      = v.ind_data;
        request_not_full     = v.nf;
        indication_not_empty = v.ne;
        req_intr_channel     = v.rintr;
        ind_intr_channel     = v.iintr;
        rdy_request_enq      = (v.delay == 0);
        rdy_indication       = (v.delay == 0);
        sb.push_back('{v.rd, v.exp_err, v.exp_data});
        if (v.rd) begin
            bus.rd_addr  = v.addr;
            bus.rd_valid = 1'b1;
        end else begin
            bus.wr_addr  = v.addr;
            bus.wr_data  = v.wdata;
            bus.wr_valid = 1'b1;
        end
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = v.rd ? bus.rd_ready : bus.wr_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.rd_valid = 1'b0;
        bus.wr_valid = 1'b0;
        chk("accept", {31'd0, acc}, 32'd1);
        lat = 0;
        while (acc && lat < 400 &&
               !(v.rd ? bus.rd_resp_valid : bus.wr_resp_valid)) begin
            @(posedge clk);
            #1;
            lat++;
            rdy_request_enq = (lat >= v.delay);
            rdy_indication  = (lat >= v.delay);
        end
        chk("latency", lat, v.exp_lat);
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("resp_seen", sb.size(), 32'd0);
        sb.delete();
        chk("en_request_cnt", enr_cnt - enr0, v.exp_enr);
        chk("en_indication_cnt", eni_cnt - eni0, v.exp_eni);
        chk("select_request", {30'd0, select_request}, {30'd0, v.exp_selr});
        chk("select_indication", {30'd0, select_indication}, {30'd0, v.exp_seli});
        if (v.exp_enr == 1) chk("enq_data", request_enq_v, v.wdata);
        rdy_request_enq = 1'b0;
        rdy_indication  = 1'b0;
    endtask

    initial begin
        int n;
        int enr0;
        bit accw;
        rst_n = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_resp_ready = 1'b1;
        bus.rd_valid = 1'b0;
        bus.rd_addr = '0;
        bus.rd_resp_ready = 1'b1;
        rdy_request_enq = 1'b1;
        rdy_indication = 1'b1;
        request_not_full = 1'b1;
        indication_not_empty = 1'b1;
        indication_data = 32'h1234_5678;
        req_intr_channel = 32'd5;
        ind_intr_channel = 32'd1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readys", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd0);
        chk("rst_resp_valid", {30'd0, bus.wr_resp_valid, bus.rd_resp_valid}, 32'd0);
        chk("rst_strobes", {30'd0, en_request, en_indication}, 32'd0);
        chk("rst_selects", {28'd0, select_request, select_indication}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_enq_v", request_enq_v, 32'd0);
        chk("rst_rd_data", bus.rd_resp_data, 32'd0);
        rst_n = 1'b1;
        rdy_request_enq = 1'b0;
        rdy_indication = 1'b0;
        req_intr_channel = '0;
        ind_intr_channel = '0;
        #1;
        chk("post_rst_readys", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd3);
        @(posedge clk);
        #1;

        // rd addr wdata dly ind_data nf ne rintr iintr | err data lat enr eni selr seli
        vecs.push_back('{0, 12'h040, 32'h0000_1234, 3, 32'h0, 0, 0, 0, 0,
                         0, 32'h0, 4, 1, 0, 2'd1, 2'd0});
        vecs.push_back('{1, 12'h100, 32'h0, 0, 32'hCAFE_F00D, 0, 0, 0, 0,
                         0, 32'hCAFE_F00D, 1, 0, 1, 2'd1, 2'd0});
        vecs.push_back('{1, 12'h140, 32'h0, NEVER, 32'h1111_2222, 0, 0, 0, 0,
                         1, ERR, 255, 0, 0, 2'd1, 2'd1});
        vecs.push_back('{1, 12'h180, 32'h0, 0, 32'h3333_4444, 0, 0, 0, 0,
                         1, ERR, 0, 0, 0, 2'd1, 2'd1});
        vecs.push_back('{1, 12'h044, 32'h0, 0, 32'h5555_6666, 1, 0, 0, 0,
                         0, 32'h1, 1, 0, 0, 2'd1, 2'd1});
        vecs.push_back('{1, 12'h088, 32'h0, 0, 32'h0, 0, 1, 3, 6,
                         0, 32'h3, 1, 0, 0, 2'd2, 2'd1});
        vecs.push_back('{1, 12'h104, 32'h0, 0, 32'h0, 1, 0, 5, 7,
                         0, 32'h0, 1, 0, 0, 2'd2, 2'd0});
        vecs.push_back('{1, 12'h148, 32'h0, 0, 32'h0, 0, 1, 5, 2,
                         0, 32'h2, 1, 0, 0, 2'd2, 2'd1});
        vecs.push_back('{0, 12'h0C0, 32'h0000_0BAD, 0, 32'h0, 0, 0, 0, 0,
                         1, ERR, 0, 0, 0, 2'd2, 2'd1});
        vecs.push_back('{0, 12'h00C, 32'h0000_0BAD, 0, 32'h0, 0, 0, 0, 0,
                         1, ERR, 0, 0, 0, 2'd2, 2'd1});
        vecs.push_back('{0, 12'h084, 32'h0000_0099, 0, 32'h0, 0, 0, 0, 0,
                         0, 32'h0, 1, 0, 0, 2'd2, 2'd1});
        vecs.push_back('{0, 12'h080, 32'hA5A5_5A5A, 0, 32'h0, 0, 0, 0, 0,
                         0, 32'h0, 1, 1, 0, 2'd2, 2'd1});
        vecs.push_back('{1, 12'h1C4, 32'h0, 0, 32'h0, 1, 1, 0, 0,
                         1, ERR, 0, 0, 0, 2'd2, 2'd1});
        vecs.push_back('{0, 12'h040, 32'h0000_0777, NEVER, 32'h0, 0, 0, 0, 0,
                         1, ERR, 255, 0, 0, 2'd1, 2'd1});
        foreach (vecs[i]) run_vec(vecs[i]);

        // simultaneous read and write, read response back-pressured
        enr0 = enr_cnt;
        rdy_request_enq = 1'b1;
        request_not_full = 1'b1;
        bus.rd_resp_ready = 1'b0;
        sb.push_back('{1'b1, 1'b0, 32'h1});
        sb.push_back('{1'b0, 1'b0, 32'h0});
        bus.rd_addr = 12'h044;
        bus.rd_valid = 1'b1;
        bus.wr_addr = 12'h040;
        bus.wr_data = 32'h0000_0077;
        bus.wr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rd_resp_hold_valid", {31'd0, bus.rd_resp_valid}, 32'd1);
        chk("rd_resp_hold_data", bus.rd_resp_data, 32'd1);
        chk("rd_resp_hold_wrq", {31'd0, bus.wr_resp_valid}, 32'd0);
        chk("rd_first_sb", sb.size(), 32'd2);
        bus.rd_resp_ready = 1'b1;
        n = 0;
        accw = 1'b0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            if (bus.wr_valid && bus.wr_ready) accw = 1'b1;
            @(posedge clk);
            #1;
            if (accw) bus.wr_valid = 1'b0;
            n++;
        end
        bus.wr_valid = 1'b0;
        chk("both_resp_seen", sb.size(), 32'd0);
        sb.delete();
        chk("late_write_accept", {31'd0, accw}, 32'd1);
        chk("late_write_strobe", enr_cnt - enr0, 32'd1);
        chk("late_write_data", request_enq_v, 32'h0000_0077);

        // reset in the middle of WR_WAIT
        enr0 = enr_cnt;
        rdy_request_enq = 1'b0;
        bus.wr_addr = 12'h080;
        bus.wr_data = 32'h0000_0055;
        bus.wr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rdy_request_enq = 1'b1;
        ind_intr_channel = 32'd2;
        #1;
        chk("rst_mid_no_strobe", {31'd0, en_request}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_readys", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd0);
        chk("rst_mid_sel", {30'd0, select_request}, 32'd0);
        chk("rst_mid_enq_v", request_enq_v, 32'd0);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_idle", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_no_resp", {31'd0, bus.wr_resp_valid}, 32'd0);
        chk("rst_mid_strobes", enr_cnt - enr0, 32'd0);
        rdy_request_enq = 1'b0;

`ifdef PORTAL_IRQ_MASK_EN
        chk("irq_masked", {31'd0, irq}, 32'd0);
        run_vec('{0, 12'h200, 32'h0000_0002, 0, 32'h0, 0, 0, 0, 2,
                  0, 32'h0, 0, 0, 0, 2'd0, 2'd0});
        chk("irq_unmasked", {31'd0, irq}, 32'd1);
        run_vec('{1, 12'h200, 32'h0, 0, 32'h0, 0, 0, 0, 2,
                  0, 32'h2, 0, 0, 0, 2'd0, 2'd0});
`else
        chk("irq_raw", {31'd0, irq}, 32'd1);
        run_vec('{0, 12'h200, 32'h0000_0002, 0, 32'h0, 0, 0, 0, 2,
                  1, ERR, 0, 0, 0, 2'd0, 2'd0});
`endif
        ind_intr_channel = '0;
        req_intr_channel = '0;
        #1;
        chk("irq_clear", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
